// File: rtl/banked_instr_rom.sv
// rtl/banked_instr_rom.sv - multi-bank instruction ROM with loader port and drain-safe bank switching
module banked_instr_rom #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 1024,
    parameter int NUM_BANKS = 12,
    parameter int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_valid,
    output logic              stall,
    input  logic              bank_req_valid,
    input  logic [BANK_W-1:0] bank_req_sel,
    output logic              bank_req_ack,
    output logic [BANK_W-1:0] active_bank,
    input  logic              wr_en,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              err_clear,
    output logic              err_misalign,
    output logic              err_oob
);
    localparam int WORDS = MEM_BYTES / 4;
    localparam int IDX_W = $clog2(WORDS);

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] DRAIN  = 2'd1;
    localparam logic [1:0] SWITCH = 2'd2;

    logic [DATA_W-1:0] mem [NUM_BANKS][WORDS];
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [BANK_W-1:0] sel_q;
    logic              rd_acc;
    logic              rd_mis;
    logic              rd_oob;
    logic              wr_mis;
    logic              wr_oob;
    logic              wr_ok;
    logic              sw_oob;
    logic              set_mis;
    logic              set_oob;

    // addr+3 >= MEM_BYTES is rewritten as addr > MEM_BYTES-4 so it cannot overflow
    always_comb begin
        rd_acc  = rd_en && (state == RUN);
        rd_mis  = address[1:0] != 2'b00;
        rd_oob  = address > ADDR_W'(MEM_BYTES - 4);
        wr_mis  = wr_addr[1:0] != 2'b00;
        wr_oob  = (wr_addr > ADDR_W'(MEM_BYTES - 4)) || (32'(wr_bank) >= NUM_BANKS);
        wr_ok   = wr_en && !wr_mis && !wr_oob;
        sw_oob  = (state == SWITCH) && (32'(sel_q) >= NUM_BANKS);
        set_mis = (rd_acc && rd_mis) || (wr_en && wr_mis);
        set_oob = (rd_acc && rd_oob) || (wr_en && wr_oob) || sw_oob;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (bank_req_valid) state_nxt = DRAIN;
            DRAIN:   state_nxt = SWITCH;
            SWITCH:  state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            stall        <= 1'b0;
            bank_req_ack <= 1'b0;
            active_bank  <= '0;
            sel_q        <= '0;
        end else begin
            state        <= state_nxt;
            stall        <= state_nxt != RUN;
            bank_req_ack <= state_nxt == SWITCH;
            if ((state == RUN) && bank_req_valid)
                sel_q <= bank_req_sel;
            if ((state == SWITCH) && !sw_oob)
                active_bank <= sel_q;
        end
    end

    // Reads sample the array before this edge's write lands: read-before-write
    always_ff @(posedge clk) begin
        if (reset) begin
            instruction <= '0;
            instr_valid <= 1'b0;
        end else begin
            instr_valid <= rd_acc;
            if (rd_acc)
                instruction <= (rd_mis || rd_oob) ? '0 : mem[active_bank][address[IDX_W+1:2]];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_bank][wr_addr[IDX_W+1:2]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_misalign <= 1'b0;
            err_oob      <= 1'b0;
        end else begin
            err_misalign <= set_mis || (err_misalign && !err_clear);
            err_oob      <= set_oob || (err_oob && !err_clear);
        end
    end

    a_data_w:    assert property (@(posedge clk) DATA_W == 32);
    a_mem_pow2:  assert property (@(posedge clk) (MEM_BYTES & (MEM_BYTES - 1)) == 0);
    a_addr_no_x: assert property (@(posedge clk) disable iff (reset) rd_en |-> !$isunknown(address));
endmodule

// File: tb/tb_banked_instr_rom.sv
// tb/tb_banked_instr_rom.sv - scoreboard bench for banked_instr_rom
module tb_banked_instr_rom;
    localparam int ADDR_W    = 64;
    localparam int DATA_W    = 32;
    localparam int MEM_BYTES = 1024;
    localparam int NUM_BANKS = 12;
    localparam int BANK_W    = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              rd_en;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] instruction;
    logic              instr_valid;
    logic              stall;
    logic              bank_req_valid;
    logic [BANK_W-1:0] bank_req_sel;
    logic              bank_req_ack;
    logic [BANK_W-1:0] active_bank;
    logic              wr_en;
    logic [BANK_W-1:0] wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              err_clear;
    logic              err_misalign;
    logic              err_oob;

    always #5 clk = ~clk;

    banked_instr_rom #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BYTES(MEM_BYTES), .NUM_BANKS(NUM_BANKS), .BANK_W(BANK_W)
    ) dut (
        .clk(clk), .reset(reset), .rd_en(rd_en), .address(address),
        .instruction(instruction), .instr_valid(instr_valid), .stall(stall),
        .bank_req_valid(bank_req_valid), .bank_req_sel(bank_req_sel), .bank_req_ack(bank_req_ack),
        .active_bank(active_bank), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
        .wr_data(wr_data), .err_clear(err_clear), .err_misalign(err_misalign), .err_oob(err_oob)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    bit          mon_en   = 1'b0;
    int          mdl_bank = 0;
    logic [31:0] mdl [NUM_BANKS][MEM_BYTES/4];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Every cycle either the oldest pending read is due, or instr_valid must be low
    exp_t e;
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                check("rd_valid", 64'(instr_valid), 64'd1);
                check("rd_data", 64'(instruction), 64'(e.data));
            end else begin
                check("idle_valid", 64'(instr_valid), 64'd0);
            end
        end
    end

    function automatic logic [31:0] exp_rd(input logic [63:0] a);
        if (a[1:0] != 2'b00 || a > 64'(MEM_BYTES - 4))
            return 32'd0;
        return mdl[mdl_bank][a[9:2]];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_rd(input logic [63:0] a);
        exp_t x;
        x.data = exp_rd(a);
        x.due  = cyc + 1;
        rd_en   = 1'b1;
        address = a;
        exp_q.push_back(x);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic load(input int b, input logic [63:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_bank = BANK_W'(b);
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
        if (a[1:0] == 2'b00 && a <= 64'(MEM_BYTES - 4) && b < NUM_BANKS)
            mdl[b][a[9:2]] = d;
    endtask

    task automatic clear_errs();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rd_en = 1'b0; address = '0; bank_req_valid = 1'b0; bank_req_sel = '0;
        wr_en = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0; err_clear = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++)
            for (int w = 0; w < MEM_BYTES / 4; w++)
                mdl[b][w] = 32'd0;

        tick();
        mon_en = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_instruction", 64'(instruction), 64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_ack", 64'(bank_req_ack), 64'd0);
        check("rst_active", 64'(active_bank), 64'd0);
        check("rst_errs", {62'd0, err_misalign, err_oob}, 64'd0);

        // plain back-to-back reads
        load(0, 0, 32'h9100_0421);
        load(0, 4, 32'hD503_201F);
        issue_rd(0);
        issue_rd(4);
        tick();
        check("plain_errs", {62'd0, err_misalign, err_oob}, 64'd0);

        // bank switch overlapping a read; rd_en pulsed while stalled
        load(3, 0, 32'hAAAA_5555);
        bank_req_valid = 1'b1;
        bank_req_sel   = 4'd3;
        issue_rd(0);
        check("drain_stall", 64'(stall), 64'd1);
        check("drain_ack", 64'(bank_req_ack), 64'd0);
        check("drain_active", 64'(active_bank), 64'd0);
        rd_en = 1'b1; address = 64'd2;
        tick();
        check("switch_stall", 64'(stall), 64'd1);
        check("switch_ack", 64'(bank_req_ack), 64'd1);
        bank_req_valid = 1'b0;
        tick();
        rd_en = 1'b0;
        check("run_stall", 64'(stall), 64'd0);
        check("run_ack", 64'(bank_req_ack), 64'd0);
        check("run_active", 64'(active_bank), 64'd3);
        check("stalled_rd_noerr", 64'(err_misalign), 64'd0);
        mdl_bank = 3;
        issue_rd(0);

        // illegal reads and sticky flags
        issue_rd(2);
        check("mis_flag", 64'(err_misalign), 64'd1);
        check("mis_no_oob", 64'(err_oob), 64'd0);
        issue_rd(1024);
        check("oob_flag", 64'(err_oob), 64'd1);
        tick(); tick();
        check("sticky", {62'd0, err_misalign, err_oob}, 64'd3);
        clear_errs();
        check("cleared", {62'd0, err_misalign, err_oob}, 64'd0);
        err_clear = 1'b1;
        issue_rd(6);
        err_clear = 1'b0;
        check("set_wins", 64'(err_misalign), 64'd1);
        check("set_wins_oob", 64'(err_oob), 64'd0);
        clear_errs();
        load(3, 1020, 32'hCAFE_F00D);
        issue_rd(1020);
        check("edge_legal", {62'd0, err_misalign, err_oob}, 64'd0);
        issue_rd(1021);
        check("edge_both", {62'd0, err_misalign, err_oob}, 64'd3);
        clear_errs();

        // loader hazards
        load(3, 20, 32'h0BAD_C0DE);
        wr_en = 1'b1; wr_bank = 4'd3; wr_addr = 64'd20; wr_data = 32'h1234_5678;
        issue_rd(20);
        wr_en = 1'b0;
        mdl[3][5] = 32'h1234_5678;
        issue_rd(20);
        load(13, 0, 32'hDEAD_BEEF);
        check("wr_bad_bank", 64'(err_oob), 64'd1);
        clear_errs();
        load(3, 1024, 32'hDEAD_BEEF);
        check("wr_oob_addr", 64'(err_oob), 64'd1);
        load(3, 1, 32'hDEAD_BEEF);
        check("wr_mis", 64'(err_misalign), 64'd1);
        issue_rd(0);
        clear_errs();

        // request for a nonexistent bank
        bank_req_valid = 1'b1;
        bank_req_sel   = 4'd13;
        tick();
        tick();
        check("bad_sel_ack", 64'(bank_req_ack), 64'd1);
        bank_req_valid = 1'b0;
        tick();
        check("bad_sel_active", 64'(active_bank), 64'd3);
        check("bad_sel_oob", 64'(err_oob), 64'd1);
        check("bad_sel_stall", 64'(stall), 64'd0);
        clear_errs();

        // reset during DRAIN aborts the switch
        bank_req_valid = 1'b1;
        bank_req_sel   = 4'd1;
        tick();
        check("pre_rst_stall", 64'(stall), 64'd1);
        reset = 1'b1;
        bank_req_valid = 1'b0;
        tick();
        reset = 1'b0;
        mdl_bank = 0;
        check("abort_active", 64'(active_bank), 64'd0);
        check("abort_stall", 64'(stall), 64'd0);
        check("abort_ack", 64'(bank_req_ack), 64'd0);
        tick();
        check("abort_no_late_ack", 64'(bank_req_ack), 64'd0);
        bank_req_valid = 1'b1;
        bank_req_sel   = 4'd3;
        tick();
        tick();
        check("resume_ack", 64'(bank_req_ack), 64'd1);
        bank_req_valid = 1'b0;
        tick();
        check("resume_active", 64'(active_bank), 64'd3);
        mdl_bank = 3;
        issue_rd(0);

        tick();
        tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
